// File: rtl/dma_pkg.sv
// Shared opcode, word-count mode and FSM state encodings for the DMA address
// controller.
package dma_pkg;

  localparam logic [2:0] OP_WR_CR   = 3'd0;
  localparam logic [2:0] OP_RD_CR   = 3'd1;
  localparam logic [2:0] OP_RD_WC   = 3'd2;
  localparam logic [2:0] OP_RD_AC   = 3'd3;
  localparam logic [2:0] OP_REINIT  = 3'd4;
  localparam logic [2:0] OP_LD_ADDR = 3'd5;
  localparam logic [2:0] OP_LD_WC   = 3'd6;
  localparam logic [2:0] OP_ENABLE  = 3'd7;

  localparam logic [1:0] MODE_DOWN = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_ACMP = 2'b10;
  localparam logic [1:0] MODE_FREE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dma_term_detect.sv
// Terminal-count detection for the step currently being taken, evaluated
// from the pre-step word counter and the post-step address.
module dma_term_detect
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] wc,
  input  logic [W-1:0] wcr,
  input  logic [W-1:0] ac_next,
  output logic         terminal
);

  logic [W-1:0] wc_inc;
  assign wc_inc = wc + W'(1);

  always_comb begin
    terminal = 1'b0;
    case (mode)
      MODE_DOWN: terminal = (wc == W'(1));
      MODE_UP:   terminal = (wc_inc == wcr);
      MODE_ACMP: terminal = (ac_next == wcr);
      default:   terminal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dma_addr_ctrl.sv
// DMA address generator control: instruction decode, control/address/word-count
// registers, IDLE/RUN/DONE sequencing and register read-back.
module dma_addr_ctrl
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic [2:0]   instr,
  input  logic         instr_valid,
  input  logic [W-1:0] data_in,
  input  logic         step,
  output logic [W-1:0] addr_out,
  output logic [W-1:0] data_out,
  output logic         data_oe,
  output logic         running,
  output logic         done
);

  logic [2:0]   cr;
  logic [W-1:0] ar, ac, wcr, wc;
  logic [W-1:0] ac_next, wc_next;
  logic         step_acc, terminal;
  state_t       state, state_nxt;

  // Down and address-compare modes start from wcr; the others count from zero.
  function automatic logic [W-1:0] wc_init(input logic [1:0] mode, input logic [W-1:0] v);
    return (mode == MODE_DOWN || mode == MODE_ACMP) ? v : '0;
  endfunction

  // Any instruction in the same cycle takes priority over a step.
  assign step_acc = step && !instr_valid && (state == ST_RUN);
  assign ac_next  = cr[2] ? ac - W'(1) : ac + W'(1);

  always_comb begin
    wc_next = wc;
    case (cr[1:0])
      MODE_DOWN: wc_next = wc - W'(1);
      MODE_ACMP: wc_next = wc;
      default:   wc_next = wc + W'(1);
    endcase
  end

  dma_term_detect #(.W(W)) u_term (
    .mode     (cr[1:0]),
    .wc       (wc),
    .wcr      (wcr),
    .ac_next  (ac_next),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (!res_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (instr_valid && instr == OP_REINIT) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (instr_valid && instr == OP_ENABLE) state_nxt = ST_RUN;
        ST_RUN:  if (step_acc && terminal)               state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cr       <= '0;
      ar       <= '0;
      ac       <= '0;
      wcr      <= '0;
      wc       <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_oe  <= 1'b0;
      data_out <= '0;
      if (instr_valid) begin
        case (instr)
          OP_WR_CR: cr <= data_in[2:0];
          OP_RD_CR: begin data_oe <= 1'b1; data_out <= {{(W-3){1'b0}}, cr}; end
          OP_RD_WC: begin data_oe <= 1'b1; data_out <= wc; end
          OP_RD_AC: begin data_oe <= 1'b1; data_out <= ac; end
          OP_REINIT: begin
            ac <= ar;
            wc <= wc_init(cr[1:0], wcr);
          end
          OP_LD_ADDR: begin
            ar <= data_in;
            ac <= data_in;
          end
          OP_LD_WC: begin
            wcr <= data_in;
            wc  <= wc_init(cr[1:0], data_in);
          end
          default: ;
        endcase
      end else if (step_acc) begin
        ac <= ac_next;
        wc <= wc_next;
      end
    end
  end

  assign addr_out = ac;
  assign running  = (state == ST_RUN);
  assign done     = (state == ST_DONE);

endmodule

// File: doc/dma_addr_ctrl.md
# dma_addr_ctrl

Control and sequencing unit for the DMA address generator. It decodes the 3-bit microprocessor instruction stream and holds the control register, the address register/counter and the word-count register/counter. On each transfer step it advances the address and word counters according to the programmed mode and direction. It flags terminal count to the bus-side DMA logic and returns register contents on the data bus.

## Interface
- W, 8, width of the address and word-count paths; multiple of 4, legal range 4..16.
- clk  in  1  rising-edge clock, sole clock domain.
- res_n  in  1  synchronous, active-low reset.
- instr  in  3  instruction opcode, sampled when instr_valid=1.
- instr_valid  in  1  instruction strobe, one instruction per cycle.
- data_in  in  W  write data for WR_CR / LD_ADDR / LD_WC; only bits [2:0] are used by WR_CR.
- step  in  1  transfer-step request; acted on only in RUN.
- addr_out  out  W  current address counter (registered).
- data_out  out  W  read-back data; forced to 0 when data_oe=0.
- data_oe  out  1  read data valid, one-cycle pulse.
- running  out  1  high in state RUN.
- done  out  1  high in state DONE (terminal count reached).

## Operation
- Opcodes:
  - 0 WR_CR: cr <= data_in[2:0].
  - 1 RD_CR.
  - 2 RD_WC.
  - 3 RD_AC.
  - 4 REINIT: ac <= ar; wc <= mode init value; state <= IDLE.
  - 5 LD_ADDR: ar <= data_in and ac <= data_in.
  - 6 LD_WC: wcr <= data_in; wc <= mode init value computed from data_in.
  - 7 ENABLE.
- cr[1:0] is the word-count mode:
  - 00 count-down: wc init = wcr. Each step, wc <= wc-1. Terminal when wc==1 at the step, i.e. wc reaches 0. wcr=0 gives 2^W transfers.
  - 01 count-up: wc init = 0. Each step, wc <= wc+1. Terminal when wc+1==wcr. wcr=0 gives 2^W transfers.
  - 10 address-compare: wc init = wcr and wc is held. Terminal when the next ac equals wcr.
  - 11 free-run: wc init = 0 and wc increments. Never terminal.
- cr[2] is the address direction: 0 = up (+1), 1 = down (-1). All arithmetic wraps modulo 2^W.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ENABLE moves to RUN.
  - RUN: a step with a terminal condition moves to DONE. ENABLE has no effect.
  - DONE: step and ENABLE are ignored. REINIT moves to IDLE. LD_ADDR/LD_WC load registers but keep the state at DONE.
  - REINIT from any state moves to IDLE.
- In RUN, a step always updates ac and wc in the same edge, including the terminal step.
- WR_CR while in RUN applies from the next step. wc is not reinitialised.
- Simultaneous events: when instr_valid=1, step is ignored that cycle for every opcode.
- res_n=0 mid-transfer aborts immediately: all state is cleared and no done is flagged.
- Reset values: cr, ar, ac, wcr, wc = 0; state = IDLE; addr_out = 0; data_out = 0; data_oe = 0; running = 0; done = 0.

## Timing
- All instruction effects are visible the cycle after the sampling edge.
- Reads (RD_CR/RD_WC/RD_AC):
  - data_oe=1 and data_out = the register value before that edge, during the next cycle only.
  - cr is zero-extended to W.
  - Back-to-back reads produce back-to-back pulses.
- A step accepted at edge N gives updated addr_out in cycle N+1. If that step was terminal, done=1 and running=0 also from cycle N+1.
- ENABLE at edge N sets running=1 from cycle N+1, so the earliest accepted step is at edge N+1.
- Reset: res_n sampled low at an edge gives reset values in the following cycle.

## Structure
- Package dma_pkg:
  - opcode constants OP_WR_CR..OP_ENABLE;
  - mode constants MODE_DOWN, MODE_UP, MODE_ACMP, MODE_FREE;
  - FSM state encoding ST_IDLE/ST_RUN/ST_DONE.
- One sub-module, dma_term_detect (combinational). Inputs: mode, wc, wcr, next ac. Output: terminal. Parameterised by W.
- Counters, registers, FSM and read mux live in dma_addr_ctrl.

## Test plan
- Reset: run with res_n=0 for 1 cycle, then RD_CR and RD_AC → data_out=0 with data_oe=1. done=0, running=0, addr_out=0.
- Mode 00, W=8:
  - Setup: WR_CR 3'b000, LD_ADDR 0x10, LD_WC 3, ENABLE.
  - 3 steps → addr_out 0x11, 0x12, 0x13 and wc 2, 1, 0. done=1 after the third step.
  - A 4th step → no change.
- Mode 01 with down direction:
  - Setup: WR_CR 3'b101, LD_ADDR 0x00, LD_WC 2, ENABLE.
  - Steps → addr 0xFF then 0xFE, wc 1 then 2. done after the 2nd step.
- Mode 10:
  - Setup: WR_CR 3'b010, LD_ADDR 0x05, LD_WC 0x08.
  - Steps → done exactly when addr_out=0x08, after 3 steps. RD_WC → 0x08.
- Collisions and recovery:
  - step asserted together with RD_AC in RUN → step ignored and the addr unchanged.
  - REINIT in DONE → addr 0x10, wc 3, IDLE.
  - res_n=0 mid-RUN → all outputs 0.
- Mode 11 wrap:
  - Setup: WR_CR 3'b011, LD_ADDR 0xFF, ENABLE.
  - Step → addr_out 0x00, done stays 0, wc 1.
